// File: rtl/css_mcu0_dmi_sync_pkg.sv
// Shared constants and helpers for the DMI multi-channel event synchroniser.
// Optional glitch filter is enabled with CSS_MCU0_DMI_SYNC_GLITCH_FILTER_EN.
package css_mcu0_dmi_sync_pkg;

    localparam logic EVT_RISE   = 1'b0;
    localparam logic EVT_TOGGLE = 1'b1;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 2;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/css_mcu0_dmi_evt_sync_chan.sv
// One event channel: TCK-to-core synchroniser, optional glitch filter, edge detect,
// pending and sticky overrun. Filter built only with CSS_MCU0_DMI_SYNC_GLITCH_FILTER_EN.
module css_mcu0_dmi_evt_sync_chan
    import css_mcu0_dmi_sync_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic EDGE_MODE   = EVT_RISE,
    parameter int   FILT_LEN    = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    input  logic accept_i,
    input  logic clr_i,
    output logic pending_o,
    output logic sticky_o,
    output logic ovr_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   pending_q, pending_d;
    logic                   sticky_q, sticky_d;
    logic                   lvl;
    logic                   det;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

`ifdef CSS_MCU0_DMI_SYNC_GLITCH_FILTER_EN
    localparam int              FCNT_W   = $clog2(FILT_LEN + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

    logic              filt_q;
    logic [FCNT_W-1:0] fcnt_q;

    // F follows L only once L has disagreed for FILT_LEN consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FCNT_LAST) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    assign det = (EDGE_MODE == EVT_TOGGLE) ? (lvl ^ hist_q) : (lvl & ~hist_q);

    // A new edge on a channel accepted this cycle re-arms pending rather than overrunning.
    assign ovr_o     = det & pending_q & ~accept_i;
    assign pending_d = det | (pending_q & ~accept_i);
    assign sticky_d  = (sticky_q & ~clr_i) | ovr_o;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= 1'b0;
            pending_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            hist_q    <= lvl;
            pending_q <= pending_d;
            sticky_q  <= sticky_d;
        end
    end

    assign pending_o = pending_q;
    assign sticky_o  = sticky_q;

endmodule

// File: rtl/css_mcu0_dmi_multi_evt_sync.sv
// N-channel JTAG-to-core event synchroniser with fixed-priority single-issue output.
// Optional per-channel glitch filter: define CSS_MCU0_DMI_SYNC_GLITCH_FILTER_EN.
module css_mcu0_dmi_multi_evt_sync
    import css_mcu0_dmi_sync_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [NUM_CH-1:0] EDGE_MODE   = '0,
    parameter int                CNT_W       = 8,
    parameter int                FILT_LEN    = DEF_FILT_LEN,
    localparam int               CH_W        = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] async_evt_i,
    output logic              evt_valid_o,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic [NUM_CH-1:0] evt_onehot_o,
    input  logic              evt_ready_i,
    output logic [NUM_CH-1:0] pending_o,
    output logic [NUM_CH-1:0] ovr_sticky_o,
    output logic [CNT_W-1:0]  ovr_cnt_o,
    input  logic              ovr_clr_i
);

    localparam int               SUM_W   = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ovr;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] sel_oh;
    logic [CH_W-1:0]   sel_idx;
    logic [SUM_W-1:0]  ovr_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        css_mcu0_dmi_evt_sync_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE[i]),
            .FILT_LEN    (FILT_LEN)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .async_i   (async_evt_i[i]),
            .accept_i  (accept[i]),
            .clr_i     (ovr_clr_i),
            .pending_o (pending[i]),
            .sticky_o  (ovr_sticky_o[i]),
            .ovr_o     (ovr[i])
        );
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_idx = '0;
        sel_oh  = '0;
        // Walk downward so the lowest-index pending channel is the one left selected.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx    = CH_W'(i);
                sel_oh     = '0;
                sel_oh[i]  = 1'b1;
            end
        end
    end

    assign evt_valid_o  = |pending;
    assign evt_ch_o     = sel_idx;
    assign evt_onehot_o = sel_oh;
    assign accept       = sel_oh & {NUM_CH{evt_ready_i}};
    assign pending_o    = pending;

    // Clear takes effect before this cycle's overruns are added.
    always_comb begin
        ovr_sum = ovr_clr_i ? '0 : SUM_W'(cnt_q);
        for (int i = 0; i < NUM_CH; i++) begin
            ovr_sum = ovr_sum + SUM_W'(ovr[i]);
        end
        cnt_d = (ovr_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ovr_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovr_cnt_o = cnt_q;

endmodule

// File: doc/css_mcu0_dmi_multi_evt_sync.md
Name: css_mcu0_dmi_multi_evt_sync

Overview:
- Parametrised N-channel JTAG(TCK)-to-core event synchroniser.
- Successor to the fixed 2-channel rd/wr edge synchroniser; sits between the DMI JTAG TAP and the core DMI register interface.
- Per channel:
  - configurable synchroniser depth and edge mode (rising or toggle);
  - a pending bit that holds each event until the core accepts it;
  - overrun detection.
- Single-issue output with fixed-priority arbitration, so simultaneous events are serialised, not merged.

Parameters:
NUM_CH, 2, number of event channels (1..16); channel 0 highest priority
SYNC_STAGES, 2, flop stages per synchroniser (>=2)
EDGE_MODE, '0, NUM_CH-bit vector; bit i=0 rising-edge event, 1 any-edge (toggle) event
CNT_W, 8, overrun counter width
FILT_LEN, 2, glitch-filter stability length in cycles (used only with the optional feature)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
async_evt_i  in  NUM_CH  level/toggle event lines from TCK domain
evt_valid_o  out  1  an event is presented
evt_ch_o  out  $clog2(NUM_CH) (min 1)  index of presented channel
evt_onehot_o  out  NUM_CH  one-hot of presented channel, 0 when !evt_valid_o
evt_ready_i  in  1  core accepts presented event
pending_o  out  NUM_CH  per-channel pending bits
ovr_sticky_o  out  NUM_CH  per-channel sticky overrun flags
ovr_cnt_o  out  CNT_W  total overruns, saturating
ovr_clr_i  in  1  clears ovr_sticky_o and ovr_cnt_o

Behaviour:
- Reset:
  - Reset is synchronous and active-high; clk is the only clock.
  - While rst=1 at a clk edge, all flops clear: sync chains, history, pending, sticky, counter, filter counters.
  - All outputs read 0.
  - An input held high across reset release produces one event in rising and toggle modes (history resets to 0); this is intended.
- Sync chain: s[0]<=async_evt_i[i]; s[k]<=s[k-1]. Synced level L=s[SYNC_STAGES-1]. History H<=L each cycle.
- Edge detect, combinational:
  - rising mode: det=L&~H;
  - toggle mode: det=L^H.
- Latency: counting the first clk edge that samples the new input level as edge 1:
  - pending_o[i] and evt_valid_o rise after edge SYNC_STAGES+1.
  - This is 3 cycles at the default depth.
  - This requires no older pending event and a higher-priority channel not blocking.
- Pending per channel:
  - set on det; cleared on accept (evt_valid_o & evt_ready_i & channel selected);
  - if det and accept hit the same channel in one cycle, pending stays 1 (new event retained, no overrun).
- Overrun:
  - condition: det while pending=1 and that channel is not being accepted this cycle;
  - effect: event dropped, ovr_sticky_o[i] set, ovr_cnt_o incremented by the number of channels overrunning this cycle;
  - the counter saturates at 2^CNT_W-1.
- ovr_clr_i in the same cycle as an overrun: clear applies first, then the new overrun.
  - Sticky ends set for the overrunning channels only.
  - Count ends equal to this cycle's overrun count.
- Arbitration:
  - evt_ch_o = lowest-index pending channel; evt_valid_o=|pending.
  - Outputs are driven combinationally from registered pending (no comb path from async_evt_i).
  - Presented channel changes only after acceptance or when a higher-priority pending bit sets. Core must sample evt_ch_o in the accept cycle.
- evt_ready_i without evt_valid_o: no effect.
- Throughput: one accept per cycle. Simultaneous events on k channels drain in k consecutive cycles with ready held high.
- Minimum event spacing without overrun: 1 core cycle after acceptance. Source-side pulse width must be >= SYNC_STAGES+1 core cycles (caller's responsibility).

Optional Feature:
- Macro: CSS_MCU0_DMI_SYNC_GLITCH_FILTER_EN.
- Defined:
  - per-channel counter, width $clog2(FILT_LEN+1);
  - filtered level F updates to L only after L differs from F for FILT_LEN consecutive cycles; the counter resets whenever L==F;
  - edge detect uses F/H instead of L/H;
  - latency grows by FILT_LEN cycles;
  - pulses shorter than FILT_LEN synced cycles produce no event.
- Undefined: no counter or F logic; L feeds edge detect directly.

Decomposition:
- Package css_mcu0_dmi_sync_pkg holds:
  - edge-mode constants EVT_RISE=1'b0, EVT_TOGGLE=1'b1;
  - default SYNC_STAGES/FILT_LEN localparams;
  - function for channel-index width (min 1).
- Sub-module css_mcu0_dmi_evt_sync_chan holds per-channel sync chain, optional filter, edge detect, pending and sticky.
- Top level holds arbiter, overrun counter and generate loop.

Test Plan:
- Rising default, ready=1: async_evt_i[0] 0->1 -> evt_valid_o=1, evt_ch_o=0 after edge 3; single-cycle pulse on evt_valid_o; pending_o=0 next cycle.
- Simultaneous: channels 0 and 1 rise same cycle, ready=1 -> accepts ch0 then ch1 on consecutive cycles; evt_onehot_o=01 then 10.
- Overrun: ready=0, ch1 set to toggle mode, two toggles 5 cycles apart -> ovr_sticky_o[1]=1, ovr_cnt_o=1, pending_o[1]=1, one accept then idle.
- Saturation/clear: CNT_W=2, force 5 overruns -> ovr_cnt_o=3; ovr_clr_i same cycle as overrun on ch0 -> ovr_cnt_o=1, only sticky[0] set.
- Mid-operation reset: rst=1 while pending_o=2'b11 -> all outputs 0 at the next edge; input held high -> one event after release.
- Filter macro, FILT_LEN=2: 1-cycle input glitch -> no event; 4-cycle pulse -> exactly one event, latency 5 cycles.
